// File: rtl/core_phase_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_phase_ctrl_pkg
//  Description : State encoding, phase vector type and phase decode helper
//                shared by the RockWave phase sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package core_phase_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } phase_state_t;

    typedef struct packed {
        logic fetch;
        logic decode;
        logic execute;
        logic memory;
        logic writeback;
    } phase_vec_t;

    // IDLE and HALT drive no phase at all.
    function automatic phase_vec_t decode_phase(input phase_state_t st);
        phase_vec_t v;
        v = '0;
        case (st)
            ST_FETCH:     v.fetch     = 1'b1;
            ST_DECODE:    v.decode    = 1'b1;
            ST_EXECUTE:   v.execute   = 1'b1;
            ST_MEMORY:    v.memory    = 1'b1;
            ST_WRITEBACK: v.writeback = 1'b1;
            default:      v = '0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_perf_counter.sv
`default_nettype none
// ============================================================================
//  Module      : core_perf_counter
//  Description : Free-running wrap-around event counter with synchronous clear.
//  Revision    : 1.0  initial release
// ============================================================================
module core_perf_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/core_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : core_phase_ctrl
//  Description : Multi-cycle F/D/E/M/W phase sequencer with per-stage stall
//                hold, writeback commit strobe and debug halt at instruction
//                boundaries. Optional perf counters under CORE_PERF_COUNT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module core_phase_ctrl
    import core_phase_ctrl_pkg::*;
#(
    parameter int RESET_IDLE_CYCLES = 2,
    parameter int CNT_W             = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic stall_fetch,
    input  logic stall_decode,
    input  logic stall_execute,
    input  logic stall_memory,
    input  logic stall_writeback,
    input  logic halt_req,
    output logic phase_fetch,
    output logic phase_decode,
    output logic phase_execute,
    output logic phase_memory,
    output logic phase_writeback,
    output logic commit,
    output logic halted
`ifdef CORE_PERF_COUNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    localparam logic [3:0] c_idle_load = 4'(RESET_IDLE_CYCLES - 1);

    if (RESET_IDLE_CYCLES < 1 || RESET_IDLE_CYCLES > 15) begin : g_bad_idle_cycles
        $error("core_phase_ctrl: RESET_IDLE_CYCLES must be 1..15");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("core_phase_ctrl: CNT_W must be at least 1");
    end

    phase_state_t r_state;
    phase_state_t w_next_state;
    logic [3:0]   r_idle_cnt;
    phase_vec_t   r_phase;
    logic         r_halted;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      if (r_idle_cnt == 4'd0) w_next_state = ST_FETCH;
            ST_FETCH:     if (!stall_fetch)       w_next_state = ST_DECODE;
            ST_DECODE:    if (!stall_decode)      w_next_state = ST_EXECUTE;
            ST_EXECUTE:   if (!stall_execute)     w_next_state = ST_MEMORY;
            ST_MEMORY:    if (!stall_memory)      w_next_state = ST_WRITEBACK;
            // halt_req is only sampled here so an instruction always completes.
            ST_WRITEBACK: if (!stall_writeback)   w_next_state = halt_req ? ST_HALT : ST_FETCH;
            ST_HALT:      if (!halt_req)          w_next_state = ST_FETCH;
            default:                              w_next_state = ST_IDLE;
        endcase
    end

    // Phase flags are registered from the next state so each output is a
    // flop and cannot glitch on state-bit decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idle_cnt <= c_idle_load;
            r_phase    <= '0;
            r_halted   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_phase  <= decode_phase(w_next_state);
            r_halted <= (w_next_state == ST_HALT);
            if (r_state == ST_IDLE && r_idle_cnt != 4'd0) begin
                r_idle_cnt <= r_idle_cnt - 4'd1;
            end
        end
    end

    assign phase_fetch     = r_phase.fetch;
    assign phase_decode    = r_phase.decode;
    assign phase_execute   = r_phase.execute;
    assign phase_memory    = r_phase.memory;
    assign phase_writeback = r_phase.writeback;
    assign halted          = r_halted;
    assign commit          = r_phase.writeback & ~stall_writeback;

`ifdef CORE_PERF_COUNT_EN
    core_perf_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (1'b1),
        .count (cycle_cnt)
    );

    core_perf_counter #(.WIDTH(CNT_W)) u_instret_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (commit),
        .count (instret_cnt)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_phase_ctrl
//  Description : Directed + random scoreboard bench for core_phase_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_core_phase_ctrl;

    localparam int IDLE_N = 2;
    localparam int CW     = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall_fetch = 1'b0, stall_decode = 1'b0, stall_execute = 1'b0;
    logic stall_memory = 1'b0, stall_writeback = 1'b0;
    logic halt_req = 1'b0;
    logic phase_fetch, phase_decode, phase_execute, phase_memory, phase_writeback;
    logic commit, halted;
`ifdef CORE_PERF_COUNT_EN
    logic [CW-1:0] cycle_cnt, instret_cnt;
`endif

    logic       wrap_clr = 1'b1;
    logic       wrap_inc = 1'b0;
    logic [3:0] wrap_cnt;

    always #5 clk = ~clk;

    core_phase_ctrl #(.RESET_IDLE_CYCLES(IDLE_N), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_fetch     (stall_fetch),
        .stall_decode    (stall_decode),
        .stall_execute   (stall_execute),
        .stall_memory    (stall_memory),
        .stall_writeback (stall_writeback),
        .halt_req        (halt_req),
        .phase_fetch     (phase_fetch),
        .phase_decode    (phase_decode),
        .phase_execute   (phase_execute),
        .phase_memory    (phase_memory),
        .phase_writeback (phase_writeback),
        .commit          (commit),
        .halted          (halted)
`ifdef CORE_PERF_COUNT_EN
        ,
        .cycle_cnt       (cycle_cnt),
        .instret_cnt     (instret_cnt)
`endif
    );

    core_perf_counter #(.WIDTH(4)) u_wrap (
        .clk   (clk),
        .clear (wrap_clr),
        .inc   (wrap_inc),
        .count (wrap_cnt)
    );

    typedef struct {
        logic [4:0]  ph;
        logic        hlt;
        longint      cc;
        longint      ic;
    } exp_t;

    exp_t   sb[$];
    int     commit_cycles[$];
    int     n_vec = 0;
    int     n_err = 0;
    int     cyc = 0;
    int     first_fetch = -1;
    int     mem_cnt = 0;
    int     m_st = 0;
    int     m_idle = IDLE_N - 1;
    longint m_cc = 0;
    longint m_ic = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cc_at(input int i);
        return (commit_cycles.size() > i) ? commit_cycles[i] : -1;
    endfunction

    // One clock: drive inputs, check combinational commit, advance the
    // reference model, then compare registered outputs after the edge.
    task automatic step(input logic rst_i, input logic [4:0] stl, input logic hlt);
        exp_t e;
        logic exp_commit;
        reset = rst_i;
        {stall_fetch, stall_decode, stall_execute, stall_memory, stall_writeback} = stl;
        halt_req = hlt;
        #1;
        exp_commit = (m_st == 5) && !stl[0];
        check("commit", 64'(commit), 64'(exp_commit));
        if (commit === 1'b1) commit_cycles.push_back(cyc);
        if (rst_i) begin
            m_st = 0; m_idle = IDLE_N - 1; m_cc = 0; m_ic = 0;
        end else begin
            m_cc++;
            if (exp_commit) m_ic++;
            case (m_st)
                0:          if (m_idle == 0) m_st = 1; else m_idle--;
                1, 2, 3, 4: if (!stl[5 - m_st]) m_st++;
                5:          if (!stl[0]) m_st = hlt ? 6 : 1;
                6:          if (!hlt) m_st = 1;
                default:    m_st = 0;
            endcase
        end
        e.ph  = (m_st >= 1 && m_st <= 5) ? (5'b10000 >> (m_st - 1)) : 5'b00000;
        e.hlt = (m_st == 6);
        e.cc  = m_cc;
        e.ic  = m_ic;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        check("phases", 64'({phase_fetch, phase_decode, phase_execute, phase_memory, phase_writeback}), 64'(e.ph));
        check("halted", 64'(halted), 64'(e.hlt));
`ifdef CORE_PERF_COUNT_EN
        check("cycle_cnt", cycle_cnt, e.cc);
        check("instret_cnt", instret_cnt, e.ic);
`endif
        if (phase_fetch === 1'b1 && first_fetch < 0) first_fetch = cyc;
        if (phase_memory === 1'b1) mem_cnt++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {stall_fetch, stall_decode, stall_execute, stall_memory, stall_writeback} = 5'b0;
        halt_req = 1'b0;
        @(posedge clk);
        #1;
        m_st = 0; m_idle = IDLE_N - 1; m_cc = 0; m_ic = 0;
        cyc = 0; first_fetch = -1;
        commit_cycles.delete();
        check("rst_phases", 64'({phase_fetch, phase_decode, phase_execute, phase_memory, phase_writeback}), 64'd0);
        check("rst_commit", 64'(commit), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
`ifdef CORE_PERF_COUNT_EN
        check("rst_cycle_cnt", cycle_cnt, 64'd0);
        check("rst_instret_cnt", instret_cnt, 64'd0);
`endif
    endtask

    task automatic run_until(input int target, input string tag);
        for (int k = 0; k < 40 && m_st != target; k++) step(1'b0, 5'b0, 1'b0);
        check(tag, 64'(m_st == target), 64'd1);
    endtask

    initial begin
        int base;
        int left;
        logic sm;

        // Reset release, stall-free stream
        do_reset();
        repeat (17) step(1'b0, 5'b0, 1'b0);
        check("first_fetch_cycle", 64'(first_fetch), 64'd2);
        check("commit_count", 64'(commit_cycles.size()), 64'd3);
        check("commit_c0", 64'(cc_at(0)), 64'd6);
        check("commit_c1", 64'(cc_at(1)), 64'd11);
        check("commit_c2", 64'(cc_at(2)), 64'd16);

        // Three stall_memory cycles during MEMORY
        left = 3; mem_cnt = 0;
        for (int k = 0; k < 30 && commit_cycles.size() < 4; k++) begin
            sm = (m_st == 4) && (left > 0);
            step(1'b0, {3'b000, sm, 1'b0}, 1'b0);
            if (sm) left--;
        end
        check("mem_hold_cycles", 64'(mem_cnt), 64'd4);
        check("stalled_instr_len", 64'(cc_at(3) - cc_at(2)), 64'd8);

        // stall_execute during FETCH is ignored
        run_until(1, "reach_fetch");
        step(1'b0, 5'b00100, 1'b0);
        check("fetch_ignores_ex_stall", 64'(phase_decode), 64'd1);

        // Halt requested during DECODE
        run_until(2, "reach_decode");
        base = commit_cycles.size();
        for (int k = 0; k < 20 && m_st != 6; k++) step(1'b0, 5'b0, 1'b1);
        check("halt_commit_done", 64'(commit_cycles.size() - base), 64'd1);
        check("halt_entered", 64'(halted), 64'd1);
        repeat (3) step(1'b0, 5'b0, 1'b1);
        step(1'b0, 5'b0, 1'b0);
        check("halt_exit_fetch", 64'(phase_fetch), 64'd1);
        check("halt_exit_halted", 64'(halted), 64'd0);

        // Random stalls and sparse halt requests
        for (int k = 0; k < 80; k++) begin
            step(1'b0,
                 {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
                 ($urandom_range(0, 9) == 0));
        end

        // Reset pulsed during EXECUTE, restart timing matches first release
        run_until(3, "reach_execute");
        do_reset();
        repeat (7) step(1'b0, 5'b0, 1'b0);
        check("restart_first_fetch", 64'(first_fetch), 64'd2);
        check("restart_commit_c0", 64'(cc_at(0)), 64'd6);

`ifdef CORE_PERF_COUNT_EN
        do_reset();
        for (int k = 0; k < 80 && commit_cycles.size() < 10; k++) step(1'b0, 5'b0, 1'b0);
        check("perf_cycle_cnt_52", cycle_cnt, 64'd52);
        check("perf_instret_10", instret_cnt, 64'd10);
`endif

        // 4-bit counter wrap
        wrap_clr = 1'b1; wrap_inc = 1'b0;
        @(posedge clk); #1;
        check("wrap_clear", 64'(wrap_cnt), 64'd0);
        wrap_clr = 1'b0; wrap_inc = 1'b1;
        repeat (15) begin @(posedge clk); #1; end
        check("wrap_at_15", 64'(wrap_cnt), 64'd15);
        wrap_inc = 1'b0;
        @(posedge clk); #1;
        check("wrap_hold", 64'(wrap_cnt), 64'd15);
        wrap_inc = 1'b1;
        @(posedge clk); #1;
        check("wrap_to_0", 64'(wrap_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/core_phase_ctrl.md
# core_phase_ctrl

Multi-cycle phase sequencer for the RockWave core. It steps the single-issue datapath through fetch, decode, execute, memory and writeback, holding each phase while that stage's stall is asserted. It issues the writeback commit strobe that Fetch and CSR use to latch the next PC, and provides a debug halt at instruction boundaries. It sits in the StateMachine block, between the five stage modules.

## Interface
Parameters:
- RESET_IDLE_CYCLES, 2: cycles spent in IDLE after reset release before the first FETCH (1..15).
- CNT_W, 64: width of the performance counters (used only with CORE_PERF_COUNT_EN).

Ports:
- clk  in  1  core clock.
- reset  in  1  reset; synchronous and active-high.
- stall_fetch / stall_decode / stall_execute / stall_memory / stall_writeback  in  1 each  hold the current phase while high; ignored outside the stage's own phase.
- halt_req  in  1  debug halt request, level.
- phase_fetch / phase_decode / phase_execute / phase_memory / phase_writeback  out  1 each  one-hot phase indication, registered.
- commit  out  1  writeback completes this cycle; Fetch/CSR latch next_pc_wf / next_pc_wc.
- halted  out  1  core parked in HALT.
- cycle_cnt  out  CNT_W  cycles since reset (only with CORE_PERF_COUNT_EN).
- instret_cnt  out  CNT_W  committed instructions (only with CORE_PERF_COUNT_EN).

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT. Encoding is 3-bit binary. Phase outputs are decoded from the state register and are glitch-free.
- IDLE: a 4-bit counter loads RESET_IDLE_CYCLES-1 on reset and decrements each cycle. When it reaches 0 -> FETCH.
- FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK. Each transition happens on the first cycle that the current stage's stall is low. While that stall is high, stay in the state.
- WRITEBACK with stall_writeback low:
  - commit=1 (combinational: phase_writeback & ~stall_writeback).
  - Next state is HALT if halt_req=1, else FETCH.
- HALT: halted=1. All phase outputs are 0 and commit is 0. Go to FETCH on the first cycle halt_req=0.
- halt_req asserted mid-instruction takes no effect until the next commit, so the instruction always completes.
- Stall inputs of non-current phases have no effect.
- Interrupt redirect is not decided here. The PC chosen at commit (mtvec/mepc/jump/+4) comes from writeback; this block only times the strobe.

## Timing
- Reset values: state=IDLE, all phase_* = 0, commit=0, halted=0, counters=0.
- reset asserted in any state returns to IDLE on the next edge, including mid-instruction and in HALT. Any partial instruction is discarded.
- Minimum instruction time with no stalls is 5 cycles. Each stall cycle adds exactly one cycle.
- First phase_fetch appears RESET_IDLE_CYCLES cycles after the first clock edge with reset=0.
- commit is high exactly one cycle per instruction. It is never high in two consecutive cycles.
- Exit from HALT takes 1 cycle: halt_req falls at cycle n, and phase_fetch=1 at cycle n+1.

## Configuration
- CORE_PERF_COUNT_EN defined:
  - cycle_cnt increments every cycle that the core is not in reset, including IDLE and HALT.
  - instret_cnt increments on each commit.
  - Both counters wrap modulo 2^CNT_W.
- Not defined: the counter ports are absent and no counter logic is generated.

## Structure
- State encodings (ST_IDLE…ST_HALT) go in core_general.vh alongside the existing opcode/USE_RD constants.
- Sub-module core_perf_counter (width parameter, inc enable, synchronous clear). It is instantiated twice under CORE_PERF_COUNT_EN.

## Test plan
- Reset release, no stalls, RESET_IDLE_CYCLES=2 -> phase_fetch at cycle 2; phase pattern F,D,E,M,W repeats with period 5; commit at cycles 6, 11, 16.
- stall_memory high 3 cycles during MEMORY -> phase_memory held 4 cycles; instruction takes 8 cycles; single commit.
- stall_execute held high during FETCH -> no effect; F lasts 1 cycle.
- halt_req raised during DECODE -> instruction completes with commit; then halted=1 and phases are 0; halt_req low -> FETCH next cycle.
- reset pulsed during EXECUTE -> IDLE; outputs zero next cycle; restart timing identical to first release.
- CORE_PERF_COUNT_EN, 10 stall-free instructions from reset -> instret_cnt=10 and cycle_cnt=52 at the cycle after the 10th commit; wrap test with CNT_W=4 -> 15 goes to 0.
